// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style timing generator: counters, sync/blank decode and frame/line strobes.
// Optional frame counter output is built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int CNT_W    = 11,
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             sof,
    output logic             eol
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (1 << CNT_W)) begin : g_h_total_too_big
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_v_total_too_big
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end

    // Decode limits carry one extra bit so a total of exactly 2^CNT_W cannot alias to 0.
    localparam logic [CNT_W:0]   H_BLANK_START = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   H_SYNC_START  = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   H_SYNC_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   V_BLANK_START = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   V_SYNC_START  = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   V_SYNC_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_LAST        = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST        = CNT_W'(V_TOTAL - 1);

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] next_h;
    logic [CNT_W-1:0] next_v;
    logic [CNT_W:0]   next_h_x;
    logic [CNT_W:0]   next_v_x;

    always_comb begin
        h_wrap   = (hcount == H_LAST);
        v_wrap   = (vcount == V_LAST);
        next_h   = h_wrap ? '0 : hcount + CNT_W'(1);
        next_v   = vcount;
        if (h_wrap) begin
            next_v = v_wrap ? '0 : vcount + CNT_W'(1);
        end
        next_h_x = {1'b0, next_h};
        next_v_x = {1'b0, next_v};
    end

    // Outputs are decoded from the next counter values so count and decode land together.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount <= '0;
            vcount <= '0;
            hblnk  <= 1'b0;
            vblnk  <= 1'b0;
            hsync  <= ~H_POL;
            vsync  <= ~V_POL;
            sof    <= 1'b0;
            eol    <= 1'b0;
        end else if (ce) begin
            hcount <= next_h;
            vcount <= next_v;
            hblnk  <= (next_h_x >= H_BLANK_START);
            vblnk  <= (next_v_x >= V_BLANK_START);
            hsync  <= ((next_h_x >= H_SYNC_START) && (next_h_x < H_SYNC_END)) ? H_POL : ~H_POL;
            vsync  <= ((next_v_x >= V_SYNC_START) && (next_v_x < V_SYNC_END)) ? V_POL : ~V_POL;
            sof    <= h_wrap & v_wrap;
            eol    <= (next_h == H_LAST);
        end else begin
            sof    <= 1'b0;
            eol    <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Steps on the same edge that raises sof, so the new frame number appears with the strobe.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (ce && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default, tiny (CNT_W at its limit) and medium modes
// driven by one shared ce/rst and compared each cycle against an arithmetic model.
module tb_vga_timing_gen;

    localparam int HA [3] = '{1024, 4, 20};
    localparam int HF [3] = '{24, 1, 2};
    localparam int HS [3] = '{136, 2, 3};
    localparam int HB [3] = '{160, 1, 4};
    localparam int VA [3] = '{768, 3, 10};
    localparam int VF [3] = '{3, 1, 2};
    localparam int VS [3] = '{6, 1, 2};
    localparam int VB [3] = '{29, 1, 3};
    localparam bit HP [3] = '{1'b0, 1'b1, 1'b0};
    localparam bit VP [3] = '{1'b0, 1'b1, 1'b0};

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    logic ce   = 1'b0;

    logic [10:0] h0, v0;
    logic [2:0]  h1, v1;
    logic [5:0]  h2, v2;
    logic hs0, vs0, hb0, vb0, so0, eo0;
    logic hs1, vs1, hb1, vb1, so1, eo1;
    logic hs2, vs2, hb2, vb2, so2, eo2;
    logic [15:0] fc0, fc1, fc2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    longint adv_total = 0;
    bit     adv_last  = 1'b0;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .CNT_W(11), .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
        .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]), .H_POL(HP[0]), .V_POL(VP[0])
    ) dut0 (
        .pclk(pclk), .rst(rst), .ce(ce), .hcount(h0), .vcount(v0), .hsync(hs0), .vsync(vs0),
        .hblnk(hb0), .vblnk(vb0), .sof(so0), .eol(eo0)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    vga_timing_gen #(
        .CNT_W(3), .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
        .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]), .H_POL(HP[1]), .V_POL(VP[1])
    ) dut1 (
        .pclk(pclk), .rst(rst), .ce(ce), .hcount(h1), .vcount(v1), .hsync(hs1), .vsync(vs1),
        .hblnk(hb1), .vblnk(vb1), .sof(so1), .eol(eo1)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    vga_timing_gen #(
        .CNT_W(6), .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
        .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]), .H_POL(HP[2]), .V_POL(VP[2])
    ) dut2 (
        .pclk(pclk), .rst(rst), .ce(ce), .hcount(h2), .vcount(v2), .hsync(hs2), .vsync(vs2),
        .hblnk(hb2), .vblnk(vb2), .sof(so2), .eol(eo2)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc2)
`endif
    );

`ifndef VGA_TIMING_FRAME_CNT_EN
    assign fc0 = 16'd0;
    assign fc1 = 16'd0;
    assign fc2 = 16'd0;
`endif

    task automatic check_output(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: everything follows from the number of accepted pixel advances since reset.
    always @(posedge pclk or negedge rst) begin
        if (!rst) begin
            adv_total = 0;
            adv_last  = 1'b0;
        end else if (ce) begin
            adv_total = adv_total + 1;
            adv_last  = 1'b1;
        end else begin
            adv_last  = 1'b0;
        end
    end

    task automatic compare_inst(input int i, input string nm, input int h, input int v,
                                input bit hs, input bit vs, input bit hb, input bit vb,
                                input bit so, input bit eo, input int fc);
        longint ht, vt, eh, ev, frame_len;
        bit ehs, evs;
        ht = HA[i] + HF[i] + HS[i] + HB[i];
        vt = VA[i] + VF[i] + VS[i] + VB[i];
        frame_len = ht * vt;
        eh = adv_total % ht;
        ev = (adv_total / ht) % vt;
        ehs = (eh >= HA[i] + HF[i] && eh < HA[i] + HF[i] + HS[i]) ? HP[i] : !HP[i];
        evs = (ev >= VA[i] + VF[i] && ev < VA[i] + VF[i] + VS[i]) ? VP[i] : !VP[i];
        check_output({nm, ".hcount"}, h, eh);
        check_output({nm, ".vcount"}, v, ev);
        check_output({nm, ".hsync"}, hs, ehs);
        check_output({nm, ".vsync"}, vs, evs);
        check_output({nm, ".hblnk"}, hb, eh >= HA[i]);
        check_output({nm, ".vblnk"}, vb, ev >= VA[i]);
        check_output({nm, ".eol"}, eo, adv_last && eh == ht - 1);
        check_output({nm, ".sof"}, so, adv_last && adv_total > 0 && (adv_total % frame_len) == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check_output({nm, ".frame_cnt"}, fc, (adv_total / frame_len) % 65536);
`else
        if (fc != 0) check_output({nm, ".frame_cnt_tie"}, fc, 0);
`endif
    endtask

    // Per-cycle comparison of all three instances, sampled away from the active edge.
    always @(negedge pclk) begin
        compare_inst(0, "dflt", int'(h0), int'(v0), hs0, vs0, hb0, vb0, so0, eo0, int'(fc0));
        compare_inst(1, "tiny", int'(h1), int'(v1), hs1, vs1, hb1, vb1, so1, eo1, int'(fc1));
        compare_inst(2, "med",  int'(h2), int'(v2), hs2, vs2, hb2, vb2, so2, eo2, int'(fc2));
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, " dflt.hcount"}, h0, 0);
        check_output({tag, " dflt.vcount"}, v0, 0);
        check_output({tag, " dflt.hsync"}, hs0, 1);
        check_output({tag, " dflt.vsync"}, vs0, 1);
        check_output({tag, " dflt.hblnk"}, hb0, 0);
        check_output({tag, " dflt.sof"}, so0, 0);
        check_output({tag, " dflt.eol"}, eo0, 0);
        check_output({tag, " tiny.hcount"}, h1, 0);
        check_output({tag, " tiny.hsync"}, hs1, 0);
        check_output({tag, " tiny.vsync"}, vs1, 0);
        check_output({tag, " med.vcount"}, v2, 0);
        check_output({tag, " med.vblnk"}, vb2, 0);
    endtask

    task automatic apply_stimulus();
        int tiny_sofs;
        int sof_at [$];

        repeat (3) @(negedge pclk);
        check_reset_values("reset");

        // Continuous ce: pin horizontal timing of the default mode and the tiny mode's frame.
        rst = 1'b1;
        ce  = 1'b1;
        tiny_sofs = 0;
        for (int k = 1; k <= 2700; k++) begin
            @(negedge pclk);
            if (k <= 96 && so1) tiny_sofs++;
            case (k)
                4:    check_output("lit tiny.hsync@4", hs1, 0);
                5:    check_output("lit tiny.hsync@5", hs1, 1);
                6:    check_output("lit tiny.hsync@6", hs1, 1);
                7:    check_output("lit tiny.hsync@7", hs1, 0);
                31:   check_output("lit tiny.vsync@v3", vs1, 0);
                32:   check_output("lit tiny.vsync@v4", vs1, 1);
                40:   check_output("lit tiny.vsync@v5", vs1, 0);
                47:   check_output("lit tiny.sof@47", so1, 0);
                48:   check_output("lit tiny.sof@48", so1, 1);
                96:   check_output("lit tiny.sof_count", tiny_sofs, 2);
                1023: check_output("lit dflt.hblnk@1023", hb0, 0);
                1024: check_output("lit dflt.hblnk@1024", hb0, 1);
                1047: check_output("lit dflt.hsync@1047", hs0, 1);
                1048: begin
                    check_output("lit dflt.hcount@1048", h0, 1048);
                    check_output("lit dflt.hsync@1048", hs0, 0);
                end
                1183: check_output("lit dflt.hsync@1183", hs0, 0);
                1184: check_output("lit dflt.hsync@1184", hs0, 1);
                1343: check_output("lit dflt.eol@1343", eo0, 1);
                1344: begin
                    check_output("lit dflt.hcount_wrap", h0, 0);
                    check_output("lit dflt.vcount_inc", v0, 1);
                    check_output("lit dflt.eol_single", eo0, 0);
                end
                default: ;
            endcase
        end

        // Pixel rate divided by two: the tiny frame must stretch to 96 clocks.
        for (int k = 0; k < 400; k++) begin
            ce = k[0];
            @(negedge pclk);
            if (so1) sof_at.push_back(k);
        end
        if (sof_at.size() >= 2) begin
            check_output("lit tiny.frame_len_div2", sof_at[1] - sof_at[0], 96);
        end else begin
            check_output("lit tiny.sof_seen_div2", sof_at.size(), 2);
        end

        // Random enable, with an asynchronous mid-frame abort part way through.
        for (int k = 0; k < 6000; k++) begin
            ce = ($urandom_range(0, 3) != 0);
            if (k == 3000) begin
                #2 rst = 1'b0;
                #1 check_reset_values("async");
                @(negedge pclk);
                @(negedge pclk);
                rst = 1'b1;
            end
            @(negedge pclk);
        end
    endtask

    initial begin
        apply_stimulus();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
